seq_add_sub_unit: RTL and testbench
===================================

// Module: seq_add_sub_unit
// PURPOSE
//  Parametrised multi-cycle adder/subtractor. Computes A+B+CIN or A-B-BIN over WIDTH bits.
//  Processes CHUNK bits per clock, LSB chunk first, with a registered carry/borrow chain.
//  Successor to the fixed 8-bit ripple full subtractor. Adds width/throughput scaling,
//  an add/sub mode, a START/BUSY/DONE handshake and status flags.
//  Sits between operand registers and the datapath result bus.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 2.
//  CHUNK  2  bits processed per cycle; must divide WIDTH. NCHUNK = WIDTH/CHUNK.
// PORTS
//  CLK     in   1      clock; all state changes on the rising edge.
//  RST_N   in   1      asynchronous active-low reset.
//  START   in   1      request; sampled only while BUSY=0.
//  MODE    in   1      0 = add (A+B+CIN), 1 = subtract (A-B-BIN).
//  A       in   WIDTH  minuend/augend; captured when START is accepted.
//  B       in   WIDTH  subtrahend/addend; captured when START is accepted.
//  CIN     in   1      carry-in (add) or borrow-in (sub); captured with A/B.
//  BUSY    out  1      high while an operation is in flight.
//  DONE    out  1      one-cycle pulse: RESULT and flags updated this cycle.
//  RESULT  out  WIDTH  result of last completed operation. Held until the next completion.
//  COUT    out  1      add: carry out; sub: borrow out (1 iff A < B+BIN, unsigned).
//  OVF     out  1      two's-complement signed overflow of the last operation.
//  ZERO    out  1      RESULT == 0.
// BEHAVIOUR
//  Reset (RST_N=0, asynchronous): state=IDLE. BUSY, DONE, RESULT, COUT, OVF = 0. ZERO = 1.
//    All internal operand/shift/count registers are cleared.
//  FSM IDLE -> RUN -> IDLE:
//    IDLE: START=1 at edge k latches A, B, MODE, CIN. Chunk index = 0. BUSY=1 after edge k.
//    RUN: each edge computes chunk i using the registered carry/borrow and stores it in a
//      result shift register, then increments i. Edge k+NCHUNK computes the last chunk:
//      RESULT, COUT, OVF, ZERO load; DONE=1 and BUSY=0 for the following cycle.
//  Latency: DONE is high in the cycle after edge k+NCHUNK.
//    CHUNK=WIDTH gives 1 cycle; CHUNK=1 gives WIDTH cycles.
//  DONE is a single-cycle pulse; it clears on the next edge unless a new completion occurs.
//  START while BUSY=1: ignored. No queueing; operands are not re-captured.
//  START during the DONE cycle (BUSY=0): accepted. Gives back-to-back issue, one op per
//    NCHUNK+1 cycles at most.
//  RESULT, COUT, OVF and ZERO change only at completion. They stay stable while BUSY.
//  Arithmetic is modulo 2^WIDTH.
//    Sub chunk: d = a - b - bin. Bit borrow is (~a&b) | (~(a^b)&bin), as in the full subtractor cell.
//    OVF (add) = (A[MSB]==B[MSB]) && (RESULT[MSB]!=A[MSB]).
//    OVF (sub) = (A[MSB]!=B[MSB]) && (RESULT[MSB]!=A[MSB]).
//  Wrap-around: 0x00-0x01 gives 0xFF with COUT=1. 0xFF+0x01 gives 0x00 with COUT=1 and ZERO=1.
//  Reset mid-operation: the operation is aborted, no DONE pulse, outputs go to reset values.
//  X on MODE/A/B/CIN is tolerated while START=0 (inputs not sampled).
// STRUCTURE
//  Package seq_arith_pkg:
//    MODE_ADD=1'b0 and MODE_SUB=1'b1 constants.
//    typedef enum logic {S_IDLE, S_RUN} arith_state_t.
//  Sub-module addsub_chunk #(CHUNK): combinational CHUNK-bit ripple add/sub cell.
//    Ports: a, b, mode, cbin -> d, cbout.
//    Instantiated once; the top holds the FSM, chunk counter, operand and result shift registers.
//  Elaboration-time check: WIDTH % CHUNK == 0, else $error.
// TESTING (WIDTH=8, CHUNK=2 unless stated; check every result against a reference model)
//  1. Sub: A=0xFF, B=0x00, BIN=0 -> RESULT=0xFF, COUT=0, OVF=0. DONE exactly 4 cycles after
//     the START edge, BUSY high for those 4 cycles.
//  2. Sub: 0x0F-0x02=0x0D; 0x3C-0x0A=0x32; 0x92-0x06=0x8C. Issue back-to-back, with START
//     asserted in each DONE cycle; all three DONE pulses are 5 cycles apart.
//  3. Wrap/flags:
//     sub 0x00-0x01 -> 0xFF, COUT=1.
//     sub 0x80-0x01 -> 0x7F, OVF=1.
//     add 0x7F+0x01 -> 0x80, OVF=1, COUT=0.
//     add 0xFF+0x01 -> 0x00, COUT=1, ZERO=1.
//  4. Carry/borrow-in: add 0x10+0x20 with CIN=1 -> 0x31. Sub 0x10-0x01 with BIN=1 -> 0x0E.
//  5. START pulsed during BUSY with other operands -> ignored; first result is unaffected.
//     RST_N low mid-RUN -> no DONE, outputs at reset values, next op correct.
//  6. Parameter sweep: CHUNK=1 (latency 8), CHUNK=8 (latency 1), WIDTH=16/CHUNK=4.
//     Random operands in both modes against the reference model.

Source files
------------

// File: rtl/seq_add_sub_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_arith_pkg : mode constants, FSM state type and overflow helper          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package seq_arith_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {S_IDLE, S_RUN} arith_state_t;

  // Add overflows when operand signs match; sub overflows when they differ.
  function automatic logic ovf_calc(input logic mode, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    return (((a_msb ^ b_msb) == mode) && (r_msb != a_msb));
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_add_sub_unit_if.sv
// +----------------------------------------------------------------------------+
// | seq_add_sub_unit_if : start/busy/done handshake, operands and result flags  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface seq_add_sub_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout, ovf, zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_add_sub_unit_chunk.sv
// +----------------------------------------------------------------------------+
// | addsub_chunk : combinational CHUNK-bit ripple adder / subtractor cell       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module addsub_chunk
  import seq_arith_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             mode,
  input  logic             cbin,
  output logic [CHUNK-1:0] d,
  output logic             cbout
);

  logic w_cb;

  always_comb begin
    w_cb = cbin;
    d    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      d[i] = a[i] ^ b[i] ^ w_cb;
      if (mode == MODE_SUB)
        w_cb = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_cb);
      else
        w_cb = (a[i] & b[i]) | ((a[i] ^ b[i]) & w_cb);
    end
    cbout = w_cb;
  end

endmodule

`default_nettype wire

// File: rtl/seq_add_sub_unit.sv
// +----------------------------------------------------------------------------+
// | seq_add_sub_unit : multi-cycle A+B+CIN / A-B-BIN, CHUNK bits per clock      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module seq_add_sub_unit
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_add_sub_unit_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("seq_add_sub_unit: WIDTH must be >= 2 and divisible by CHUNK");
  end

  arith_state_t     r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_mode;
  logic             r_cb;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK-1:0] w_d;
  logic             w_cbout;
  logic [WIDTH-1:0] w_sum_next;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (r_a[CHUNK-1:0]),
    .b     (r_b[CHUNK-1:0]),
    .mode  (r_mode),
    .cbin  (r_cb),
    .d     (w_d),
    .cbout (w_cbout)
  );

  // New chunk enters at the top; after NCHUNK steps chunk 0 sits at the LSB.
  assign w_sum_next = WIDTH'({w_d, r_sum} >> CHUNK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_mode   <= MODE_ADD;
      r_cb     <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_mode  <= bus.mode;
            r_cb    <= bus.cin;
            r_sum   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> CHUNK;
          r_b   <= r_b >> CHUNK;
          r_cb  <= w_cbout;
          r_sum <= w_sum_next;
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            // Low chunk of r_a/r_b now holds the operand MSBs.
            r_result <= w_sum_next;
            r_cout   <= w_cbout;
            r_ovf    <= ovf_calc(r_mode, r_a[CHUNK-1], r_b[CHUNK-1], w_d[CHUNK-1]);
            r_zero   <= (w_sum_next == '0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_add_sub_unit.sv
// +----------------------------------------------------------------------------+
// | tb_seq_add_sub_unit : directed vectors, handshake corners, parameter sweep  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_seq_add_sub_unit;
  import seq_arith_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t q_main[$];
  exp_t q_c1[$];
  exp_t q_c8[$];
  exp_t q_w16[$];
  vec_t vecs[12];

  seq_add_sub_unit_if #(.WIDTH(8)) bus();
  seq_add_sub_unit #(.WIDTH(8), .CHUNK(2)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic        sw_start;
  logic        sw_mode;
  logic        sw_cin;
  logic [15:0] sw_a;
  logic [15:0] sw_b;

  seq_add_sub_unit_if #(.WIDTH(8))  bus_c1();
  seq_add_sub_unit_if #(.WIDTH(8))  bus_c8();
  seq_add_sub_unit_if #(.WIDTH(16)) bus_w16();
  assign bus_c1.start  = sw_start;
  assign bus_c1.mode   = sw_mode;
  assign bus_c1.cin    = sw_cin;
  assign bus_c1.a      = sw_a[7:0];
  assign bus_c1.b      = sw_b[7:0];
  assign bus_c8.start  = sw_start;
  assign bus_c8.mode   = sw_mode;
  assign bus_c8.cin    = sw_cin;
  assign bus_c8.a      = sw_a[7:0];
  assign bus_c8.b      = sw_b[7:0];
  assign bus_w16.start = sw_start;
  assign bus_w16.mode  = sw_mode;
  assign bus_w16.cin   = sw_cin;
  assign bus_w16.a     = sw_a;
  assign bus_w16.b     = sw_b;

  seq_add_sub_unit #(.WIDTH(8),  .CHUNK(1)) u_c1  (.clk(clk), .rst_n(rst_n), .bus(bus_c1));
  seq_add_sub_unit #(.WIDTH(8),  .CHUNK(8)) u_c8  (.clk(clk), .rst_n(rst_n), .bus(bus_c8));
  seq_add_sub_unit #(.WIDTH(16), .CHUNK(4)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(bus_w16));

  // Whole-word reference: plain integer arithmetic, masked to the width.
  function automatic exp_t model(input int w, input logic mode, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    exp_t e;
    int ia, ib, ic, full, mask, am, bm, rm;
    mask = (1 << w) - 1;
    ia = int'(a) & mask;
    ib = int'(b) & mask;
    ic = cin ? 1 : 0;
    if (mode == MODE_SUB) begin
      full   = ia - ib - ic;
      e.cout = (ia < ib + ic);
    end else begin
      full   = ia + ib + ic;
      e.cout = ((full >> w) & 1) != 0;
    end
    e.res  = 16'(full & mask);
    am = (ia >> (w - 1)) & 1;
    bm = (ib >> (w - 1)) & 1;
    rm = (int'(e.res) >> (w - 1)) & 1;
    e.ovf  = (mode == MODE_SUB) ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
    e.zero = (e.res == 16'h0);
    return e;
  endfunction

  task automatic check_out(input string name, input exp_t e, input logic [15:0] res,
                           input logic cout, input logic ovf, input logic zero);
    total++;
    if (res !== e.res || cout !== e.cout || ovf !== e.ovf || zero !== e.zero) begin
      bad++;
      $display("FAIL %s: got res=%h cout=%b ovf=%b zero=%b, want res=%h cout=%b ovf=%b zero=%b",
               name, res, cout, ovf, zero, e.res, e.cout, e.ovf, e.zero);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s_unexpected_done: got done=1, want done=0", name);
  endtask

  always @(negedge clk) if (rst_n && bus.done) begin
    if (q_main.size() == 0) unexpected("main");
    else check_out("main", q_main.pop_front(), {8'h00, bus.result}, bus.cout, bus.ovf, bus.zero);
  end
  always @(negedge clk) if (rst_n && bus_c1.done) begin
    if (q_c1.size() == 0) unexpected("c1");
    else check_out("c1", q_c1.pop_front(), {8'h00, bus_c1.result}, bus_c1.cout, bus_c1.ovf, bus_c1.zero);
  end
  always @(negedge clk) if (rst_n && bus_c8.done) begin
    if (q_c8.size() == 0) unexpected("c8");
    else check_out("c8", q_c8.pop_front(), {8'h00, bus_c8.result}, bus_c8.cout, bus_c8.ovf, bus_c8.zero);
  end
  always @(negedge clk) if (rst_n && bus_w16.done) begin
    if (q_w16.size() == 0) unexpected("w16");
    else check_out("w16", q_w16.pop_front(), bus_w16.result, bus_w16.cout, bus_w16.ovf, bus_w16.zero);
  end

  task automatic issue_main(input logic mode, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input exp_t e);
    bus.mode  = mode;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    q_main.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Four busy cycles with RESULT held, then the one-cycle DONE pulse.
  task automatic timing_main(input logic [7:0] prev);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("busy_run", {15'h0, bus.busy}, 16'h1);
      check_val("done_run", {15'h0, bus.done}, 16'h0);
      check_val("result_hold", {8'h00, bus.result}, {8'h00, prev});
    end
    @(negedge clk);
    check_val("done_pulse", {15'h0, bus.done}, 16'h1);
    check_val("busy_at_done", {15'h0, bus.busy}, 16'h0);
  endtask

  task automatic check_reset_state(input string name);
    check_val({name, "_busy"},   {15'h0, bus.busy}, 16'h0);
    check_val({name, "_done"},   {15'h0, bus.done}, 16'h0);
    check_val({name, "_result"}, {8'h00, bus.result}, 16'h0);
    check_val({name, "_cout"},   {15'h0, bus.cout}, 16'h0);
    check_val({name, "_ovf"},    {15'h0, bus.ovf}, 16'h0);
    check_val({name, "_zero"},   {15'h0, bus.zero}, 16'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [7:0] prev;
    int lat_c1, lat_c8, lat_w16;

    //          mode      a      b      cin   res    cout  ovf   zero
    vecs[0]  = '{MODE_SUB, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{MODE_SUB, 8'h0F, 8'h02, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{MODE_SUB, 8'h3C, 8'h0A, 1'b0, 8'h32, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{MODE_SUB, 8'h92, 8'h06, 1'b0, 8'h8C, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{MODE_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{MODE_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{MODE_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{MODE_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{MODE_ADD, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{MODE_SUB, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{MODE_ADD, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{MODE_ADD, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};

    bus.start = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    sw_start = 1'b0; sw_mode = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Each op is issued in the DONE cycle of the previous one: back-to-back.
    prev = 8'h00;
    for (int i = 0; i < 12; i++) begin
      e.res = {8'h00, vecs[i].res}; e.cout = vecs[i].cout;
      e.ovf = vecs[i].ovf; e.zero = vecs[i].zero;
      issue_main(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, e);
      timing_main(prev);
      prev = vecs[i].res;
    end
    @(negedge clk);

    // START pulsed while busy must not disturb the running op.
    e.res = 16'h0040; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0;
    issue_main(MODE_SUB, 8'h50, 8'h10, 1'b0, e);
    @(negedge clk);
    @(negedge clk);
    bus.a = 8'h01; bus.b = 8'h02; bus.mode = MODE_ADD; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("busy_ignore_done", {15'h0, bus.done}, 16'h1);
    repeat (8) @(negedge clk);
    check_val("busy_ignore_idle", {15'h0, bus.busy}, 16'h0);

    // Reset mid-run: op aborted, no DONE, outputs back to reset values.
    e.res = 16'h0077; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0;
    issue_main(MODE_ADD, 8'h33, 8'h44, 1'b0, e);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    void'(q_main.pop_back());
    #1;
    check_reset_state("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_val("after_reset_idle", {15'h0, bus.busy}, 16'h0);
    e.res = 16'h001B; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0;
    issue_main(MODE_SUB, 8'h20, 8'h05, 1'b0, e);
    timing_main(8'h00);
    @(negedge clk);

    // Parameter sweep: random operands into three differently-shaped units at once.
    for (int n = 0; n < 30; n++) begin
      sw_mode  = 1'($urandom_range(0, 1));
      sw_cin   = 1'($urandom_range(0, 1));
      sw_a     = 16'($urandom);
      sw_b     = 16'($urandom);
      sw_start = 1'b1;
      q_c1.push_back(model(8, sw_mode, sw_a, sw_b, sw_cin));
      q_c8.push_back(model(8, sw_mode, sw_a, sw_b, sw_cin));
      q_w16.push_back(model(16, sw_mode, sw_a, sw_b, sw_cin));
      @(posedge clk);
      #1 sw_start = 1'b0;
      lat_c1 = -1; lat_c8 = -1; lat_w16 = -1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (bus_c1.done  && lat_c1  < 0) lat_c1  = c - 1;
        if (bus_c8.done  && lat_c8  < 0) lat_c8  = c - 1;
        if (bus_w16.done && lat_w16 < 0) lat_w16 = c - 1;
      end
      check_int("lat_chunk1", lat_c1, 8);
      check_int("lat_chunk8", lat_c8, 1);
      check_int("lat_w16", lat_w16, 4);
      check_val("sweep_idle", {13'h0, bus_c1.busy, bus_c8.busy, bus_w16.busy}, 16'h0);
    end

    repeat (3) @(negedge clk);
    check_int("q_main_empty", q_main.size(), 0);
    check_int("q_c1_empty", q_c1.size(), 0);
    check_int("q_c8_empty", q_c8.size(), 0);
    check_int("q_w16_empty", q_w16.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
